// File: rtl/updown_counter_display_if.sv
// Control and display signal bundle for updown_counter_display.
// The master side drives rate/count controls; the slave side drives LEDs and the display.
interface updown_counter_display_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 8,
  parameter int SEL_W  = 5
);
  logic [SEL_W-1:0]  s;
  logic              en;
  logic              ud;
  logic              mode;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  cnt;
  logic              tc;
  logic [6:0]        cnode;
  logic [DIGITS-1:0] an;
  logic              dp;

  modport master (
    output s,
    output en,
    output ud,
    output mode,
    output load,
    output load_val,
    input  cnt,
    input  tc,
    input  cnode,
    input  an,
    input  dp
  );

  modport slave (
    input  s,
    input  en,
    input  ud,
    input  mode,
    input  load,
    input  load_val,
    output cnt,
    output tc,
    output cnode,
    output an,
    output dp
  );
endinterface

// File: rtl/updown_counter_display.sv
// Parametrised up/down counter with rate prescaler, load, wrap/saturate
// and a multiplexed active-low hex seven-segment display.
module updown_counter_display #(
  parameter int WIDTH          = 16,
  parameter int DIGITS         = 8,
  parameter int SEL_W          = 5,
  parameter int REFRESH_CYCLES = 100000
) (
  input logic                     clk,
  input logic                     rst,
  updown_counter_display_if.slave bus
);

  localparam int PW = 2**SEL_W;
  localparam int RW =
    (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DW =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int XW = 4 * DIGITS;

  logic [PW-1:0]     presc;
  logic [PW-1:0]     tick_mask;
  logic              tick;
  logic [WIDTH-1:0]  cnt;
  logic              tc;
  logic              at_end;
  logic [WIDTH-1:0]  cnt_next;
  logic [RW-1:0]     ref_cnt;
  logic [DW-1:0]     dig;
  logic [XW-1:0]     cnt_ext;
  logic [3:0]        nib;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an_next;
  logic [6:0]        cnode;
  logic [DIGITS-1:0] an;
  logic              dp;

  // Tick when the low s+1 prescaler bits are all ones.
  always_comb begin
    tick_mask = '0;
    for (int i = 0; i < PW; i++) begin
      if (i <= int'(bus.s)) tick_mask[i] = 1'b1;
    end
  end

  assign tick = bus.en & (&(presc | ~tick_mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (!bus.en) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign at_end = bus.ud ? (cnt == '1)
                         : (cnt == '0);

  // Natural +1/-1 overflow gives the wrap case.
  always_comb begin
    cnt_next = cnt;
    if (!(at_end && bus.mode)) begin
      cnt_next = bus.ud ? cnt + WIDTH'(1)
                        : cnt - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (bus.load) begin
      cnt <= bus.load_val;
      tc  <= 1'b0;
    end else if (tick) begin
      cnt <= cnt_next;
      tc  <= at_end;
    end else begin
      tc  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      dig     <= '0;
    end else if (ref_cnt == RW'(REFRESH_CYCLES - 1)) begin
      ref_cnt <= '0;
      if (dig == DW'(DIGITS - 1)) dig <= '0;
      else                        dig <= dig + DW'(1);
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  always_comb begin
    cnt_ext = '0;
    cnt_ext[WIDTH-1:0] = cnt;
  end

  // Digits entirely above the counter width stay dark.
  always_comb begin
    nib     = 4'h0;
    an_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig == DW'(i)) begin
        nib = cnt_ext[4*i +: 4];
        if (4 * i < WIDTH) an_next[i] = 1'b0;
      end
    end
  end

  always_comb begin
    seg = 7'b1000000;
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b0000011;
      4'hc: seg = 7'b1000110;
      4'hd: seg = 7'b0100001;
      4'he: seg = 7'b0000110;
      4'hf: seg = 7'b0001110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an    <= {{(DIGITS-1){1'b1}}, 1'b0};
      cnode <= 7'b1000000;
      dp    <= 1'b1;
    end else begin
      an    <= an_next;
      cnode <= seg;
      dp    <= ~((dig == '0) && !bus.en);
    end
  end

  assign bus.cnt   = cnt;
  assign bus.tc    = tc;
  assign bus.an    = an;
  assign bus.cnode = cnode;
  assign bus.dp    = dp;

endmodule

// File: tb/tb_updown_counter_display.sv
// Directed bench for updown_counter_display (WIDTH=8, DIGITS=4,
// SEL_W=3, REFRESH_CYCLES=4).
module tb_updown_counter_display;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  updown_counter_display_if #(
    .WIDTH(8), .DIGITS(4), .SEL_W(3)
  ) bus ();

  updown_counter_display #(
    .WIDTH(8), .DIGITS(4), .SEL_W(3),
    .REFRESH_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.s = 3'd0;
    bus.en = 1'b1;
    bus.ud = 1'b1;
    bus.mode = 1'b0;
    bus.load = 1'b0;
    bus.load_val = 8'h00;

    cyc(2);
    chk("rst_cnt",   32'(bus.cnt),   32'h00);
    chk("rst_tc",    32'(bus.tc),    32'h0);
    chk("rst_an",    32'(bus.an),    32'b1110);
    chk("rst_cnode", 32'(bus.cnode), 32'b1000000);
    chk("rst_dp",    32'(bus.dp),    32'h1);

    rst = 1'b0;
    cyc(2);
    chk("s0_first", 32'(bus.cnt), 32'h01);
    cyc(2);
    chk("s0_second", 32'(bus.cnt), 32'h02);

    bus.en = 1'b0;
    cyc(1);
    bus.s = 3'd2;
    bus.en = 1'b1;
    cyc(7);
    chk("s2_before", 32'(bus.cnt), 32'h02);
    cyc(1);
    chk("s2_first", 32'(bus.cnt), 32'h03);
    cyc(8);
    chk("s2_second", 32'(bus.cnt), 32'h04);
    bus.en = 1'b0;
    cyc(3);
    chk("pause_hold", 32'(bus.cnt), 32'h04);
    bus.en = 1'b1;
    cyc(7);
    chk("reen_before", 32'(bus.cnt), 32'h04);
    cyc(1);
    chk("reen_step", 32'(bus.cnt), 32'h05);

    // wrap up / down
    bus.en = 1'b0;
    bus.s = 3'd0;
    bus.load = 1'b1;
    bus.load_val = 8'hfe;
    cyc(1);
    chk("ld_fe", 32'(bus.cnt), 32'hfe);
    bus.load = 1'b0;
    bus.en = 1'b1;
    cyc(2);
    chk("wrap_ff", 32'(bus.cnt), 32'hff);
    chk("wrap_ff_tc", 32'(bus.tc), 32'h0);
    cyc(2);
    chk("wrap_00", 32'(bus.cnt), 32'h00);
    chk("wrap_00_tc", 32'(bus.tc), 32'h1);
    cyc(1);
    chk("wrap_tc_once", 32'(bus.tc), 32'h0);
    bus.ud = 1'b0;
    cyc(1);
    chk("wrap_dn_ff", 32'(bus.cnt), 32'hff);
    chk("wrap_dn_tc", 32'(bus.tc), 32'h1);
    cyc(1);
    chk("wrap_dn_tc_once", 32'(bus.tc), 32'h0);

    // saturate up
    bus.en = 1'b0;
    bus.mode = 1'b1;
    bus.ud = 1'b1;
    bus.load = 1'b1;
    bus.load_val = 8'hff;
    cyc(1);
    bus.load = 1'b0;
    bus.en = 1'b1;
    cyc(2);
    chk("sat_up_cnt", 32'(bus.cnt), 32'hff);
    chk("sat_up_tc1", 32'(bus.tc), 32'h1);
    cyc(1);
    chk("sat_up_gap", 32'(bus.tc), 32'h0);
    cyc(1);
    chk("sat_up_tc2", 32'(bus.tc), 32'h1);
    chk("sat_up_cnt2", 32'(bus.cnt), 32'hff);

    // saturate down
    bus.en = 1'b0;
    bus.ud = 1'b0;
    bus.load = 1'b1;
    bus.load_val = 8'h00;
    cyc(1);
    bus.load = 1'b0;
    bus.en = 1'b1;
    cyc(2);
    chk("sat_dn_cnt", 32'(bus.cnt), 32'h00);
    chk("sat_dn_tc", 32'(bus.tc), 32'h1);
    cyc(1);
    chk("sat_dn_gap", 32'(bus.tc), 32'h0);

    // load coincident with a tick that would wrap with tc
    bus.en = 1'b0;
    bus.mode = 1'b0;
    bus.ud = 1'b1;
    bus.load = 1'b1;
    bus.load_val = 8'hff;
    cyc(1);
    bus.load = 1'b0;
    bus.en = 1'b1;
    cyc(1);
    bus.load = 1'b1;
    bus.load_val = 8'h5a;
    cyc(1);
    chk("ld_prio_cnt", 32'(bus.cnt), 32'h5a);
    chk("ld_prio_tc", 32'(bus.tc), 32'h0);

    // reset beats load
    rst = 1'b1;
    bus.load_val = 8'h77;
    cyc(1);
    chk("rst_ld_cnt", 32'(bus.cnt), 32'h00);
    chk("rst_ld_tc", 32'(bus.tc), 32'h0);

    // display scan of 0x3C while paused
    rst = 1'b0;
    bus.en = 1'b0;
    bus.load_val = 8'h3c;
    cyc(1);
    bus.load = 1'b0;
    chk("dsp_an_e1", 32'(bus.an), 32'b1110);
    cyc(1);
    chk("dsp_an_e2", 32'(bus.an), 32'b1110);
    chk("dsp_seg_c", 32'(bus.cnode), 32'b1000110);
    chk("dsp_dp_0", 32'(bus.dp), 32'h0);
    cyc(2);
    chk("dsp_an_e4", 32'(bus.an), 32'b1110);
    cyc(1);
    chk("dsp_an_e5", 32'(bus.an), 32'b1101);
    chk("dsp_seg_3", 32'(bus.cnode), 32'b0110000);
    chk("dsp_dp_1", 32'(bus.dp), 32'h1);
    for (int k = 6; k <= 16; k++) begin
      cyc(1);
      chk("dsp_scan_an", 32'(bus.an),
          (k < 9) ? 32'b1101 : 32'b1111);
    end
    cyc(1);
    chk("dsp_an_e17", 32'(bus.an), 32'b1110);
    chk("dsp_seg_c2", 32'(bus.cnode), 32'b1000110);
    chk("dsp_dp_e17", 32'(bus.dp), 32'h0);
    chk("dsp_cnt", 32'(bus.cnt), 32'h3c);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
